// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: frame constants, FSM state
// encoding and the 2-of-3 majority helper used for bit decisions.
package uart_rx_pkg;

  localparam int FRAME_DATA_BITS = 8;
  localparam int FRAME_STOP_BITS = 1;
  localparam int STATE_W         = 3;

  typedef enum logic [STATE_W-1:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } state_t;

  // Two-of-three vote over the three mid-bit samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-to-consumer byte stream: valid/ready handshake plus error pulses.
interface uart_rx_if;
  import uart_rx_pkg::*;

  logic [FRAME_DATA_BITS-1:0] data;
  logic                       valid;
  logic                       ready;
  logic                       frame_err;
  logic                       overrun;

  modport master (
    output data,
    output valid,
    output frame_err,
    output overrun,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  frame_err,
    input  overrun,
    output ready
  );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  // Shift the raw input through two flops to settle metastability.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_q <= {2{RST_VAL}};
    end else begin
      ff_q <= {ff_q[0], d_i};
    end
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver, LSB first. Oversamples each bit with a free-running
// bit timer, votes three mid-bit samples, and hands completed bytes to the
// consumer through a one-deep output register with overrun detection.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_HZ = 12_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int HALF    = BIT_CYC / 2;
  localparam int CNT_W   = $clog2(BIT_CYC);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] SAMP0    = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] SAMP1    = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] RESOLVE  = CNT_W'(HALF + 1);

  logic rx_s;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [1:0]                 samp_q, samp_d;
  logic [2:0]                 bit_idx_q, bit_idx_d;
  logic [FRAME_DATA_BITS-1:0] shift_q, shift_d;
  logic [FRAME_DATA_BITS-1:0] data_q, data_d;
  logic                       valid_q, valid_d;
  logic                       fe_q, fe_d;
  logic                       ov_q, ov_d;
  logic                       rx_prev_q;
  // The synchronizer comes out of reset holding its reset value, not the
  // real line level; primed_q marks when both flops carry sampled data.
  logic [1:0]                 primed_q;

  logic at_res;
  logic bit_v;
  logic complete;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  assign at_res = (cnt_q == RESOLVE);
  assign bit_v  = maj3(samp_q[0], samp_q[1], rx_s);

  // Register FSM state, timer, samples, shift register and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= WAIT_IDLE;
      cnt_q     <= '0;
      samp_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
      rx_prev_q <= 1'b1;
      primed_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      samp_q    <= samp_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
      rx_prev_q <= rx_s;
      primed_q  <= {primed_q[0], 1'b1};
    end
  end

  // Next-state logic: bit timing, frame sequencing and output handshake.
  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    samp_d    = samp_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    fe_d      = 1'b0;
    ov_d      = 1'b0;
    complete  = 1'b0;

    if (cnt_q == SAMP0) samp_d[0] = rx_s;
    if (cnt_q == SAMP1) samp_d[1] = rx_s;

    case (state_q)
      WAIT_IDLE: begin
        cnt_d = '0;
        if (primed_q[1] && rx_s) state_d = IDLE;
      end
      IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s) state_d = START;
      end
      START: begin
        if (at_res) begin
          if (!bit_v) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (at_res) begin
          shift_d = {bit_v, shift_q[FRAME_DATA_BITS-1:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (at_res) begin
          if (bit_v) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase

    // A consume in the same cycle as a completion frees the slot, so the
    // new byte lands without an overrun.
    if (complete) begin
      if (!valid_q || bus.ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end else if (valid_q && bus.ready) begin
      valid_d = 1'b0;
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = fe_q;
  assign bus.overrun   = ov_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised and directed bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst;
  logic rx;

  uart_rx_if bus ();

  uart_rx #(.CLK_HZ(16), .BAUD(1)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: bytes the consumer should see, pulse totals.
  logic [7:0] exp_q[$];
  int         fe_exp = 0;
  int         ov_exp = 0;

  // Observations from the output side.
  logic [7:0] got_q[$];
  int         vld_cyc = 0;
  int         fe_cyc  = 0;
  int         ov_cyc  = 0;
  int         bad_pulse = 0;
  logic       fe_prev = 1'b0;
  logic       ov_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.valid) vld_cyc++;
      if (bus.valid && bus.ready) got_q.push_back(bus.data);
      if (bus.frame_err) fe_cyc++;
      if (bus.overrun) ov_cyc++;
      if ((bus.frame_err && (fe_prev || bus.overrun)) || (bus.overrun && ov_prev)) bad_pulse++;
      fe_prev = bus.frame_err;
      ov_prev = bus.overrun;
    end else begin
      fe_prev = 1'b0;
      ov_prev = 1'b0;
    end
  end

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      @(posedge clk);
      #1 rx = v;
    end
  endtask

  // One 8N1 frame; gl_bit >= 0 inverts one cycle in the middle of that data bit.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int gl_bit);
    for (int k = 0; k < 10; k++) begin
      logic v;
      v = (k == 0) ? 1'b0 : (k == 9) ? stop_ok : b[k-1];
      for (int i = 0; i < 16; i++) begin
        @(posedge clk);
        #1 rx = (gl_bit >= 0 && k == gl_bit + 1 && i == 8) ? ~v : v;
      end
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input bit stop_ok);
    if (stop_ok) exp_q.push_back(b);
    else fe_exp++;
  endtask

  task automatic compare_rx(input string tag);
    check_eq({tag, " byte count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check_eq({tag, " byte"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
    check_eq({tag, " frame_err pulses"}, fe_cyc, fe_exp);
    check_eq({tag, " overrun pulses"}, ov_cyc, ov_exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " data"}, bus.data, 0);
    check_eq({tag, " valid"}, bus.valid, 0);
    check_eq({tag, " frame_err"}, bus.frame_err, 0);
    check_eq({tag, " overrun"}, bus.overrun, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rx        = 1'b1;
    bus.ready = 1'b1;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst = 1'b0;
    drive(1'b1, 20);

    // Basic byte with the consumer always ready.
    send_frame(8'hA5, 1'b1, -1);
    model_frame(8'hA5, 1'b1);
    drive(1'b1, 20);
    compare_rx("t1");
    check_eq("t1 valid cycles", vld_cyc, 1);

    // Short low glitch must not start a frame.
    drive(1'b0, 4);
    drive(1'b1, 32);
    send_frame(8'h3C, 1'b1, -1);
    model_frame(8'h3C, 1'b1);
    drive(1'b1, 20);
    compare_rx("t2");

    // Framing error, line held low (break), then recovery.
    send_frame(8'h55, 1'b0, -1);
    model_frame(8'h55, 1'b0);
    drive(1'b0, 40);
    drive(1'b1, 32);
    send_frame(8'h0F, 1'b1, -1);
    model_frame(8'h0F, 1'b1);
    drive(1'b1, 20);
    compare_rx("t3");

    // Overrun while the consumer stalls.
    @(posedge clk);
    #1 bus.ready = 1'b0;
    send_frame(8'h11, 1'b1, -1);
    drive(1'b1, 20);
    check_eq("t4 valid after first", bus.valid, 1);
    check_eq("t4 data after first", bus.data, 8'h11);
    send_frame(8'h22, 1'b1, -1);
    ov_exp++;
    drive(1'b1, 20);
    check_eq("t4 valid after overrun", bus.valid, 1);
    check_eq("t4 data after overrun", bus.data, 8'h11);
    @(posedge clk);
    #1 bus.ready = 1'b1;
    exp_q.push_back(8'h11);
    @(posedge clk);
    #1 bus.ready = 1'b0;
    drive(1'b1, 3);
    check_eq("t4 valid after consume", bus.valid, 0);
    check_eq("t4 data retained", bus.data, 8'h11);
    bus.ready = 1'b1;
    compare_rx("t4");

    // Reset mid-frame with the line held low.
    drive(1'b0, 16);
    drive(1'b1, 16);
    drive(1'b0, 16);
    drive(1'b0, 16);
    drive(1'b0, 5);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("t5 in reset");
    rst = 1'b0;
    drive(1'b0, 40);
    check_eq("t5 no byte while low", got_q.size(), 0);
    check_eq("t5 no frame_err while low", fe_cyc, fe_exp);
    drive(1'b1, 32);
    send_frame(8'h7E, 1'b1, -1);
    model_frame(8'h7E, 1'b1);
    drive(1'b1, 20);
    compare_rx("t5");

    // Back-to-back frames, glitch inside a data bit of the second.
    send_frame(8'h00, 1'b1, -1);
    model_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1, int'($urandom_range(0, 7)));
    model_frame(8'hFF, 1'b1);
    drive(1'b1, 20);
    compare_rx("t6");

    // Random bytes, stop-bit errors, glitches and gaps (including none).
    for (int f = 0; f < 16; f++) begin
      logic [7:0] b;
      bit         ok;
      int         gl;
      b  = 8'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      gl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
      send_frame(b, ok, gl);
      model_frame(b, ok);
      if (ok) drive(1'b1, int'($urandom_range(0, 24)));
      else drive(1'b1, int'($urandom_range(20, 40)));
    end
    drive(1'b1, 20);
    compare_rx("rnd");

    check_eq("pulse width/overlap violations", bad_pulse, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
